// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared defaults, FSM encoding and the PC register index for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  // PC has no storage behind the write port
  localparam int PC_ADDR = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

endpackage

// File: rtl/regarb_fifo.sv
// Memory-return queue: storage, per-entry valid bits, wrapped pointers and address-match kill.
module regarb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              empty_next,
  output logic              full,
  output logic              any_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]     rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_idx, rd_idx;
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [DEPTH-1:0]   valid_reg, valid_next;
  logic [DEPTH-1:0]   kill_vec, wr_sel, rd_sel;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];

  // The extra MSB tells a wrapped-full queue from an empty one
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign wr_ptr_next = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
  assign rd_ptr_next = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
  assign empty_next  = (wr_ptr_next == rd_ptr_next);

  assign head_valid = !empty && valid_reg[rd_idx];
  assign head_addr  = addr_mem[rd_idx];
  assign head_data  = data_mem[rd_idx];
  assign any_valid  = |valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign kill_vec[gi] = kill_en && valid_reg[gi] && (addr_mem[gi] == kill_addr);
      assign wr_sel[gi]   = push && (wr_idx == PTR_W'(gi));
      assign rd_sel[gi]   = pop && (rd_idx == PTR_W'(gi));
      // A fresh push is never killed by the write it coincides with
      assign valid_next[gi] = wr_sel[gi] ? push_valid
                                         : (valid_reg[gi] && !kill_vec[gi] && !rd_sel[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= push_addr;
      data_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, memory returns drain idle slots.
// Optional REGARB_R15_FILTER_EN: writes addressed to the PC are consumed but never reach the port.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              stall_pipe,
  output logic              pending
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] PC        = ADDR_W'(PC_ADDR);

  logic [1:0]        state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;

  logic              push, push_valid, pop;
  logic              head_valid, empty, empty_next, full, any_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic in_force, wb_accept, wb_store, head_grant, head_killed, head_blocked, rf_we_raw;

  assign in_force  = (state_reg == ST_FORCE);
  assign wb_accept = wb_en && !in_force;

`ifdef REGARB_R15_FILTER_EN
  assign wb_store   = (wb_addr != PC);
  assign push_valid = (mem_addr != PC);
`else
  assign wb_store   = 1'b1;
  assign push_valid = 1'b1;
`endif

  assign mem_ready = !full && !rst;
  assign push      = mem_valid && mem_ready;

  // In the forced slot the head owns the port; otherwise only when the pipeline is silent
  assign head_grant   = head_valid && (in_force || !wb_en);
  assign pop          = !empty && (head_grant || !head_valid);
  assign head_killed  = wb_accept && (head_addr == wb_addr);
  assign head_blocked = head_valid && !head_grant && !head_killed;

  regarb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_valid (push_valid),
    .push_addr  (mem_addr),
    .push_data  (mem_data),
    .pop        (pop),
    .kill_en    (wb_accept),
    .kill_addr  (wb_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .empty      (empty),
    .empty_next (empty_next),
    .full       (full),
    .any_valid  (any_valid)
  );

  always_comb begin
    rf_we_raw = 1'b0;
    rf_addr   = head_addr;
    rf_data   = head_data;
    if (wb_accept) begin
      rf_we_raw = wb_store;
      rf_addr   = wb_addr;
      rf_data   = wb_data;
    end else if (head_grant) begin
      rf_we_raw = 1'b1;
    end
  end

  // Reset gates the port combinationally so no partial write escapes
  assign rf_we      = rf_we_raw && !rst;
  assign stall_pipe = in_force && !rst;
  assign pending    = any_valid;

  always_comb begin
    wait_next = wait_reg;
    if (empty || pop) begin
      wait_next = '0;
    end else if (head_valid && !head_grant && (wait_reg != WAIT_SAT)) begin
      wait_next = wait_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = empty_next ? ST_IDLE : ST_PEND;
    if (!in_force && (state_reg == ST_PEND) && head_blocked && (wait_reg == WAIT_LAST)) begin
      state_next = ST_FORCE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

endmodule
